// File: rtl/key_entry_buf.sv
`default_nettype none
// ============================================================================
// Module      : key_entry_buf
// Description : Keypad entry buffer. Turns scanner key levels into press
//               events and edits a right-aligned digit buffer (digit, backspace,
//               clear, enter). It drives the seg7 nibble vector and the last
//               committed entry.
// Revision    : 1.0 - initial release
// ============================================================================
module key_entry_buf #(
    parameter int          DIGITS = 6,
    parameter logic [3:0]  BLANK  = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_flag,
    input  logic [3:0]            key_data,
    output logic [4*DIGITS-1:0]   disp_data,
    output logic [2:0]            digit_cnt,
    output logic [4*DIGITS-1:0]   entry_value,
    output logic                  entry_done,
    output logic                  key_err
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ENTRY = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;
    localparam logic [1:0] S_SHOW  = 2'd3;

    localparam logic [3:0]          C_KEY_BKSP = 4'hA;
    localparam logic [3:0]          C_KEY_CLR  = 4'hB;
    localparam logic [3:0]          C_KEY_ENT  = 4'hC;
    localparam logic [2:0]          C_MAX_CNT  = 3'(DIGITS);
    localparam logic [4*DIGITS-1:0] C_ALL_BLANK = {DIGITS{BLANK}};

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] buf_q, buf_d;
    logic [4*DIGITS-1:0] entry_q, entry_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                key_flag_q;

    logic                w_press;
    logic                w_is_digit;
    logic [4*DIGITS-1:0] w_shift_in;
    logic [4*DIGITS-1:0] w_shift_out;
    logic [2:0]          w_cnt_inc;
    logic [2:0]          w_cnt_dec;

    // Press detection and the two buffer shift forms used by the FSM
    always_comb begin
        w_press     = key_flag & ~key_flag_q;
        w_is_digit  = (key_data <= 4'd9);
        w_shift_in  = {buf_q[4*DIGITS-5:0], key_data};
        w_shift_out = {BLANK, buf_q[4*DIGITS-1:4]};
        w_cnt_inc   = cnt_q + 3'd1;
        w_cnt_dec   = cnt_q - 3'd1;
    end

    // Entry FSM: key_data is only looked at on the detecting edge
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (w_press) begin
            if (key_data > C_KEY_ENT) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    S_EMPTY: begin
                        if (w_is_digit) begin
                            buf_d   = w_shift_in;
                            cnt_d   = w_cnt_inc;
                            state_d = (w_cnt_inc == C_MAX_CNT) ? S_FULL : S_ENTRY;
                        end else if (key_data != C_KEY_CLR) begin
                            err_d = 1'b1;
                        end
                    end
                    S_ENTRY, S_FULL: begin
                        if (w_is_digit) begin
                            if (state_q == S_FULL) begin
                                err_d = 1'b1;
                            end else begin
                                buf_d   = w_shift_in;
                                cnt_d   = w_cnt_inc;
                                state_d = (w_cnt_inc == C_MAX_CNT) ? S_FULL : S_ENTRY;
                            end
                        end else if (key_data == C_KEY_BKSP) begin
                            buf_d   = w_shift_out;
                            cnt_d   = w_cnt_dec;
                            state_d = (w_cnt_dec == 3'd0) ? S_EMPTY : S_ENTRY;
                        end else if (key_data == C_KEY_CLR) begin
                            buf_d   = C_ALL_BLANK;
                            cnt_d   = 3'd0;
                            state_d = S_EMPTY;
                        end else begin
                            entry_d = buf_q;
                            done_d  = 1'b1;
                            buf_d   = C_ALL_BLANK;
                            cnt_d   = 3'd0;
                            state_d = S_SHOW;
                        end
                    end
                    default: begin
                        // SHOW: the working buffer is already blank here
                        if (w_is_digit) begin
                            buf_d   = {C_ALL_BLANK[4*DIGITS-1:4], key_data};
                            cnt_d   = 3'd1;
                            state_d = (C_MAX_CNT == 3'd1) ? S_FULL : S_ENTRY;
                        end else if (key_data == C_KEY_CLR) begin
                            buf_d   = C_ALL_BLANK;
                            cnt_d   = 3'd0;
                            state_d = S_EMPTY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // State registers with asynchronous reset to the empty, blank display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_flag_q <= 1'b0;
            state_q    <= S_EMPTY;
            buf_q      <= C_ALL_BLANK;
            entry_q    <= C_ALL_BLANK;
            cnt_q      <= 3'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            key_flag_q <= key_flag;
            state_q    <= state_d;
            buf_q      <= buf_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Display shows the committed entry while in SHOW, else the working buffer
    always_comb begin
        disp_data   = (state_q == S_SHOW) ? entry_q : buf_q;
        digit_cnt   = cnt_q;
        entry_value = entry_q;
        entry_done  = done_q;
        key_err     = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_entry_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_entry_buf
// Description : Directed self-checking bench for key_entry_buf
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_entry_buf;

    logic        clk;
    logic        rst;
    logic        key_flag;
    logic [3:0]  key_data;
    logic [23:0] disp_data;
    logic [2:0]  digit_cnt;
    logic [23:0] entry_value;
    logic        entry_done;
    logic        key_err;

    int n_checks;
    int n_fails;

    logic p_done, p_err, a_done, a_err;

    key_entry_buf #(.DIGITS(6), .BLANK(4'hF)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_flag   (key_flag),
        .key_data   (key_data),
        .disp_data  (disp_data),
        .digit_cnt  (digit_cnt),
        .entry_value(entry_value),
        .entry_done (entry_done),
        .key_err    (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One key_flag pulse; captures pulse outputs in the cycle after the
    // detecting edge (p_*) and the cycle after that (a_*).
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_flag = 1'b1;
        key_data = k;
        @(posedge clk);
        #1;
        p_done = entry_done;
        p_err  = key_err;
        @(negedge clk);
        key_flag = 1'b0;
        @(posedge clk);
        #1;
        a_done = entry_done;
        a_err  = key_err;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        key_flag = 1'b0;
        key_data = 4'h0;
        #2;
        check("rst_disp",  32'(disp_data),   32'hFFFFFF);
        check("rst_cnt",   32'(digit_cnt),   32'd0);
        check("rst_entry", 32'(entry_value), 32'hFFFFFF);
        check("rst_pulse", {30'd0, entry_done, key_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty: backspace is an error, clear is silent
        press(4'hA);
        check("empty_bksp_err", 32'(p_err), 32'd1);
        press(4'hB);
        check("empty_clr_noerr", {30'd0, p_done, p_err}, 32'd0);

        press(4'h1); press(4'h2); press(4'h3);
        check("d123_disp", 32'(disp_data), 32'hFFF123);
        check("d123_cnt",  32'(digit_cnt), 32'd3);

        press(4'h4); press(4'h5); press(4'h6);
        check("full_disp", 32'(disp_data), 32'h123456);
        check("full_cnt",  32'(digit_cnt), 32'd6);
        press(4'h7);
        check("full_err",     32'(p_err), 32'd1);
        check("full_err_one", 32'(a_err), 32'd0);
        check("full_keep",    32'(disp_data), 32'h123456);

        press(4'hA);
        check("bksp_disp", 32'(disp_data), 32'hF12345);
        check("bksp_cnt",  32'(digit_cnt), 32'd5);

        press(4'hC);
        check("ent_done",     {30'd0, p_done, p_err}, 32'd2);
        check("ent_done_one", 32'(a_done), 32'd0);
        check("ent_value",    32'(entry_value), 32'hF12345);
        check("show_disp",    32'(disp_data), 32'hF12345);
        check("show_cnt",     32'(digit_cnt), 32'd0);

        press(4'hC);
        check("show_ent_err", {30'd0, p_done, p_err}, 32'd1);

        press(4'h9);
        check("new_disp",  32'(disp_data),   32'hFFFFF9);
        check("new_cnt",   32'(digit_cnt),   32'd1);
        check("new_entry", 32'(entry_value), 32'hF12345);

        press(4'hE);
        check("unused_err",  32'(p_err), 32'd1);
        check("unused_keep", 32'(disp_data), 32'hFFFFF9);

        // Held key with data changing: only the first code is applied
        @(negedge clk);
        key_flag = 1'b1;
        key_data = 4'h4;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 10) key_data = 4'h5;
        end
        check("hold_disp", 32'(disp_data), 32'hFFFF94);
        check("hold_cnt",  32'(digit_cnt), 32'd2);
        key_flag = 1'b0;
        @(negedge clk);

        // Clear from ENTRY, then rebuild a partial entry
        press(4'hB);
        check("clr_disp", 32'(disp_data), 32'hFFFFFF);
        press(4'h8);
        check("part_disp", 32'(disp_data), 32'hFFFFF8);

        // Asynchronous reset mid-cycle, checked before any clock edge
        #2;
        rst = 1'b1;
        #1;
        check("arst_disp",  32'(disp_data),   32'hFFFFFF);
        check("arst_cnt",   32'(digit_cnt),   32'd0);
        check("arst_entry", 32'(entry_value), 32'hFFFFFF);
        check("arst_pulse", {30'd0, entry_done, key_err}, 32'd0);

        // Key already held when reset releases counts as a fresh press
        key_flag = 1'b1;
        key_data = 4'h7;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_disp", 32'(disp_data), 32'hFFFFF7);
        check("post_rst_cnt",  32'(digit_cnt), 32'd1);
        @(negedge clk);
        key_flag = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
